// File: rtl/vga_board_capture.sv
// VGA receive-side checker: locks to the raster timing carried by hsync/vsync, samples the
// centre pixel of each of the 3x3 board cells and decodes its colour back to a 2-bit code.
module vga_board_capture #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned HS_WIDTH = 96,
  parameter int unsigned VS_WIDTH = 2,
  parameter int unsigned H_ALIGN  = 656,
  parameter int unsigned V_ALIGN  = 489,
  parameter int unsigned RGB_LAT  = 1,
  parameter int unsigned COL_X0   = 105,
  parameter int unsigned COL_X1   = 320,
  parameter int unsigned COL_X2   = 535,
  parameter int unsigned ROW_Y0   = 78,
  parameter int unsigned ROW_Y1   = 240,
  parameter int unsigned ROW_Y2   = 402
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_vga_r,
  input  logic [3:0]  i_vga_g,
  input  logic [3:0]  i_vga_b,
  output logic [17:0] o_cell_state,
  output logic        o_frame_valid,
  output logic        o_locked,
  output logic        o_timing_err,
  output logic        o_color_err
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FALL = HW'(H_ALIGN);
  localparam logic [HW-1:0] H_RISE = HW'((H_ALIGN + HS_WIDTH) % H_TOTAL);
  // Loaded on the detection cycle so the counter reads H_ALIGN there and H_ALIGN+1 after.
  localparam logic [HW-1:0] H_LOAD = HW'((H_ALIGN + 1) % H_TOTAL);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FALL = VW'(V_ALIGN);
  localparam logic [VW-1:0] V_RISE = VW'((V_ALIGN + VS_WIDTH) % V_TOTAL);
  localparam logic [VW-1:0] V_PUB  = VW'(V_ACTIVE);

  localparam logic [HW-1:0] SX0 = HW'(COL_X0 + RGB_LAT);
  localparam logic [HW-1:0] SX1 = HW'(COL_X1 + RGB_LAT);
  localparam logic [HW-1:0] SX2 = HW'(COL_X2 + RGB_LAT);
  localparam logic [VW-1:0] SY0 = VW'(ROW_Y0);
  localparam logic [VW-1:0] SY1 = VW'(ROW_Y1);
  localparam logic [VW-1:0] SY2 = VW'(ROW_Y2);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_t;

  state_t         r_state;
  state_t         w_state_d;
  logic           r_s_hs;
  logic           r_s_vs;
  logic           r_p_hs;
  logic           r_p_vs;
  logic [11:0]    r_s_rgb;
  logic [HW-1:0]  r_rx_h;
  logic [HW-1:0]  w_rx_h_d;
  logic [VW-1:0]  r_rx_v;
  logic [VW-1:0]  w_rx_v_d;
  logic [17:0]    r_shadow;
  logic [17:0]    w_shadow_d;
  logic           r_frame_ok;
  logic           w_frame_ok_d;
  logic [17:0]    r_cell_state;
  logic           r_frame_valid;
  logic           r_locked;
  logic           r_timing_err;
  logic           r_color_err;

  logic           w_hs_fall;
  logic           w_hs_rise;
  logic           w_vs_fall;
  logic           w_vs_rise;
  logic           w_h_wrap;
  logic           w_violation;
  logic           w_publish;
  logic           w_any_bad;
  logic           w_col_hit;
  logic           w_row_hit;
  logic [1:0]     w_col;
  logic [1:0]     w_row;
  logic [3:0]     w_cell;
  logic           w_sample;
  logic [1:0]     w_code;

  assign w_hs_fall = r_p_hs & ~r_s_hs;
  assign w_hs_rise = ~r_p_hs & r_s_hs;
  assign w_vs_fall = r_p_vs & ~r_s_vs;
  assign w_vs_rise = ~r_p_vs & r_s_vs;
  assign w_h_wrap  = (r_rx_h == H_LAST);

  // Raster counters and lock FSM
  always_comb begin
    w_rx_h_d    = w_h_wrap ? '0 : r_rx_h + 1'b1;
    w_rx_v_d    = r_rx_v;
    w_state_d   = r_state;
    w_violation = 1'b0;
    if (w_h_wrap) begin
      w_rx_v_d = (r_rx_v == V_LAST) ? '0 : r_rx_v + 1'b1;
    end
    unique case (r_state)
      StSearch: begin
        if (w_hs_fall) begin
          w_rx_h_d = H_LOAD;
        end
        if (w_vs_fall) begin
          w_rx_v_d  = V_FALL;
          w_state_d = StAcquire;
        end
      end
      StAcquire, StLocked: begin
        w_violation = (w_hs_fall && (r_rx_h != H_FALL)) ||
                      (w_hs_rise && (r_rx_h != H_RISE)) ||
                      (w_vs_fall && (r_rx_v != V_FALL)) ||
                      (w_vs_rise && (r_rx_v != V_RISE));
        if (w_violation) begin
          w_state_d = StSearch;
        end else if (w_vs_fall) begin
          w_state_d = StLocked;
        end
      end
      default: w_state_d = StSearch;
    endcase
  end

  // Sample-point decode
  always_comb begin
    w_col_hit = 1'b1;
    w_col     = 2'd0;
    if (r_rx_h == SX0) begin
      w_col = 2'd0;
    end else if (r_rx_h == SX1) begin
      w_col = 2'd1;
    end else if (r_rx_h == SX2) begin
      w_col = 2'd2;
    end else begin
      w_col_hit = 1'b0;
    end
    w_row_hit = 1'b1;
    w_row     = 2'd0;
    if (r_rx_v == SY0) begin
      w_row = 2'd0;
    end else if (r_rx_v == SY1) begin
      w_row = 2'd1;
    end else if (r_rx_v == SY2) begin
      w_row = 2'd2;
    end else begin
      w_row_hit = 1'b0;
    end
  end

  assign w_cell   = 4'(w_row) * 4'd3 + 4'(w_col);
  assign w_sample = (r_state != StSearch) && w_col_hit && w_row_hit;

  always_comb begin
    if (r_s_rgb == 12'hF00) begin
      w_code = 2'b01;
    end else if (r_s_rgb == 12'h0F0) begin
      w_code = 2'b10;
    end else if (r_s_rgb == 12'h000) begin
      w_code = 2'b00;
    end else begin
      w_code = 2'b11;
    end
  end

  always_comb begin
    w_shadow_d = r_shadow;
    w_any_bad  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (w_sample && (w_cell == 4'(k))) begin
        w_shadow_d[2*k +: 2] = w_code;
      end
      if (r_shadow[2*k +: 2] == 2'b11) begin
        w_any_bad = 1'b1;
      end
    end
  end

  // A frame qualifies only if LOCKED from its first pixel through the publish point.
  always_comb begin
    w_frame_ok_d = r_frame_ok;
    if ((r_state != StLocked) || w_violation) begin
      w_frame_ok_d = 1'b0;
    end else if ((r_rx_v == '0) && (r_rx_h == '0)) begin
      w_frame_ok_d = 1'b1;
    end
  end

  assign w_publish = (r_rx_v == V_PUB) && (r_rx_h == '0) && (r_state == StLocked) &&
                     r_frame_ok && !w_violation;

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_s_hs        <= 1'b1;
      r_s_vs        <= 1'b1;
      r_p_hs        <= 1'b1;
      r_p_vs        <= 1'b1;
      r_s_rgb       <= '0;
      r_rx_h        <= '0;
      r_rx_v        <= '0;
      r_state       <= StSearch;
      r_shadow      <= '0;
      r_frame_ok    <= 1'b0;
      r_cell_state  <= '0;
      r_frame_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_timing_err  <= 1'b0;
      r_color_err   <= 1'b0;
    end else begin
      r_s_hs        <= i_hsync;
      r_s_vs        <= i_vsync;
      r_p_hs        <= r_s_hs;
      r_p_vs        <= r_s_vs;
      r_s_rgb       <= {i_vga_r, i_vga_g, i_vga_b};
      r_rx_h        <= w_rx_h_d;
      r_rx_v        <= w_rx_v_d;
      r_state       <= w_state_d;
      r_shadow      <= w_shadow_d;
      r_frame_ok    <= w_frame_ok_d;
      r_frame_valid <= w_publish;
      r_color_err   <= w_publish && w_any_bad;
      r_timing_err  <= w_violation;
      r_locked      <= (w_state_d == StLocked);
      if (w_publish) begin
        r_cell_state <= r_shadow;
      end
    end
  end

  assign o_cell_state  = r_cell_state;
  assign o_frame_valid = r_frame_valid;
  assign o_locked      = r_locked;
  assign o_timing_err  = r_timing_err;
  assign o_color_err   = r_color_err;

endmodule
